// File: rtl/parking_gate_scheduler.sv
// Round-robin scheduler for parking-lot entry/exit lanes: occupancy count and per-lane barrier timers.
// Optional PARK_STATS_EN adds total_entries/total_exits grant counters.
module parking_gate_scheduler #(
    parameter int unsigned NUM_LANES        = 4,
    parameter int unsigned NUM_SLOTS        = 8,
    parameter int unsigned GATE_OPEN_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             entry_req,
    input  logic [NUM_LANES-1:0]             exit_req,
    output logic [NUM_LANES-1:0]             entry_ack,
    output logic [NUM_LANES-1:0]             exit_ack,
    output logic [NUM_LANES-1:0]             gate_open,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy,
    output logic                             full,
    output logic                             exit_err,
    output logic                             busy
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]                      total_entries,
    output logic [15:0]                      total_exits
`endif
);

    localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned OCC_W = $clog2(NUM_SLOTS + 1);
    localparam int unsigned TMR_W = $clog2(GATE_OPEN_CYCLES + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]           state, state_n;
    logic [PTR_W-1:0]     entry_ptr, entry_ptr_n;
    logic [PTR_W-1:0]     exit_ptr, exit_ptr_n;
    logic [TMR_W-1:0]     timer   [NUM_LANES];
    logic [TMR_W-1:0]     timer_n [NUM_LANES];
    logic [NUM_LANES-1:0] entry_ack_n, exit_ack_n, gate_open_n;
    logic [OCC_W-1:0]     occupancy_n;
    logic                 exit_err_n, busy_n;
    logic [PTR_W:0]       exit_pick, entry_pick;
`ifdef PARK_STATS_EN
    logic [15:0]          total_entries_n, total_exits_n;
`endif

    // Returns {found, index}: first set request at or after ptr, wrapping.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                               input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] sel;
        int unsigned      idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            idx = (32'(ptr) + k) % NUM_LANES;
            sel = PTR_W'(idx);
            if (!res[PTR_W] && req[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
        return (32'(w) == NUM_LANES - 1) ? '0 : w + PTR_W'(1);
    endfunction

    // Lanes with an open barrier are invisible to both arbiters.
    assign exit_pick  = rr_pick(exit_req  & ~gate_open, exit_ptr);
    assign entry_pick = rr_pick(entry_req & ~gate_open, entry_ptr);
    assign full       = (occupancy == OCC_W'(NUM_SLOTS));

    always_comb begin
        state_n     = state;
        entry_ptr_n = entry_ptr;
        exit_ptr_n  = exit_ptr;
        entry_ack_n = '0;
        exit_ack_n  = '0;
        occupancy_n = occupancy;
        exit_err_n  = 1'b0;
        busy_n      = 1'b0;
`ifdef PARK_STATS_EN
        total_entries_n = total_entries;
        total_exits_n   = total_exits;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            timer_n[i] = (timer[i] != '0) ? timer[i] - TMR_W'(1) : '0;
        end

        // All grant side effects land on the IDLE->GRANT edge so they are visible in the GRANT cycle.
        case (state)
            ST_IDLE: begin
                if (exit_pick[PTR_W]) begin
                    state_n                         = ST_GRANT;
                    busy_n                          = 1'b1;
                    exit_ack_n[exit_pick[PTR_W-1:0]] = 1'b1;
                    timer_n[exit_pick[PTR_W-1:0]]   = TMR_W'(GATE_OPEN_CYCLES);
                    exit_ptr_n                      = ptr_after(exit_pick[PTR_W-1:0]);
                    if (occupancy == '0) exit_err_n  = 1'b1;
                    else                 occupancy_n = occupancy - OCC_W'(1);
`ifdef PARK_STATS_EN
                    total_exits_n = total_exits + 16'd1;
`endif
                end else if (entry_pick[PTR_W] && !full) begin
                    state_n                           = ST_GRANT;
                    busy_n                            = 1'b1;
                    entry_ack_n[entry_pick[PTR_W-1:0]] = 1'b1;
                    timer_n[entry_pick[PTR_W-1:0]]    = TMR_W'(GATE_OPEN_CYCLES);
                    entry_ptr_n                       = ptr_after(entry_pick[PTR_W-1:0]);
                    occupancy_n                       = occupancy + OCC_W'(1);
`ifdef PARK_STATS_EN
                    total_entries_n = total_entries + 16'd1;
`endif
                end
            end
            ST_GRANT: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_LANES; i++) begin
            gate_open_n[i] = (timer_n[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            entry_ptr <= '0;
            exit_ptr  <= '0;
            entry_ack <= '0;
            exit_ack  <= '0;
            gate_open <= '0;
            occupancy <= '0;
            exit_err  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) timer[i] <= '0;
`ifdef PARK_STATS_EN
            total_entries <= '0;
            total_exits   <= '0;
`endif
        end else begin
            state     <= state_n;
            entry_ptr <= entry_ptr_n;
            exit_ptr  <= exit_ptr_n;
            entry_ack <= entry_ack_n;
            exit_ack  <= exit_ack_n;
            gate_open <= gate_open_n;
            occupancy <= occupancy_n;
            exit_err  <= exit_err_n;
            busy      <= busy_n;
            for (int i = 0; i < NUM_LANES; i++) timer[i] <= timer_n[i];
`ifdef PARK_STATS_EN
            total_entries <= total_entries_n;
            total_exits   <= total_exits_n;
`endif
        end
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Scoreboard bench for parking_gate_scheduler: directed test-plan phases followed by random traffic.
module tb_parking_gate_scheduler;
    localparam int NL = 4;
    localparam int NS = 8;
    localparam int G  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] entry_req = '0, exit_req = '0;
    logic [NL-1:0] entry_ack, exit_ack, gate_open;
    logic [3:0]    occupancy;
    logic          full, exit_err, busy;
`ifdef PARK_STATS_EN
    logic [15:0]   total_entries, total_exits;
    logic [15:0]   m_ent, m_ext;
`endif

    parking_gate_scheduler #(.NUM_LANES(NL), .NUM_SLOTS(NS), .GATE_OPEN_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .entry_ack(entry_ack), .exit_ack(exit_ack), .gate_open(gate_open),
        .occupancy(occupancy), .full(full), .exit_err(exit_err), .busy(busy)
`ifdef PARK_STATS_EN
        , .total_entries(total_entries), .total_exits(total_exits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_exit;
        int lane;
        int occ;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, errors = 0, cyc = 0;

    // Reference model: per-lane remaining open time, occupancy, two RR pointers, grant-in-progress flag.
    int      rem[NL];
    int      occ, eptr, xptr;
    bit      mbusy;
    bit [NL-1:0] ereq, xreq;
    bit      last_g, last_x;
    int      last_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) rem[i] = 0;
        occ = 0; eptr = 0; xptr = 0; mbusy = 0; last_g = 0;
`ifdef PARK_STATS_EN
        m_ent = 0; m_ext = 0;
`endif
    endtask

    task automatic model_next();
        int nrem[NL];
        bit g, gx;
        int w;
        exp_t e;
        g = 0; gx = 0; w = 0;
        for (int i = 0; i < NL; i++) nrem[i] = (rem[i] > 0) ? rem[i] - 1 : 0;
        if (!mbusy) begin
            for (int k = 0; k < NL; k++) begin
                int l = (xptr + k) % NL;
                if (!g && xreq[l] && rem[l] == 0) begin g = 1; gx = 1; w = l; end
            end
            if (!g && occ < NS) begin
                for (int k = 0; k < NL; k++) begin
                    int l = (eptr + k) % NL;
                    if (!g && ereq[l] && rem[l] == 0) begin g = 1; w = l; end
                end
            end
        end
        if (g) begin
            e.cyc = cyc + 1; e.is_exit = gx; e.lane = w; e.err = gx && (occ == 0);
            if (gx) begin
                if (occ > 0) occ--;
                xptr = (w + 1) % NL;
`ifdef PARK_STATS_EN
                m_ext++;
`endif
            end else begin
                occ++;
                eptr = (w + 1) % NL;
`ifdef PARK_STATS_EN
                m_ent++;
`endif
            end
            e.occ = occ;
            exp_q.push_back(e);
            nrem[w] = G;
            last_g = 1; last_x = gx; last_w = w;
        end
        mbusy = g;
        for (int i = 0; i < NL; i++) rem[i] = nrem[i];
    endtask

    // One cycle: compare the current state, drive this cycle's inputs, advance the model.
    task automatic step(input bit do_rst);
        logic [NL-1:0] eg;
        for (int i = 0; i < NL; i++) eg[i] = (rem[i] > 0);
        chk("gate_open", 32'(gate_open), 32'(eg));
        chk("occupancy", 32'(occupancy), occ);
        chk("full", 32'(full), 32'(occ == NS));
        chk("busy", 32'(busy), 32'(mbusy));
`ifdef PARK_STATS_EN
        chk("total_entries", 32'(total_entries), 32'(m_ent));
        chk("total_exits", 32'(total_exits), 32'(m_ext));
`endif
        if (last_g) begin
            if (last_x) xreq[last_w] = 1'b0;
            else        ereq[last_w] = 1'b0;
        end
        last_g    = 0;
        entry_req = ereq;
        exit_req  = xreq;
        rst       = do_rst;
        if (do_rst) model_reset();
        else        model_next();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    // Monitor: every cycle either the predicted grant appears or the ack/err outputs stay quiet.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("entry_ack", 32'(entry_ack), e.is_exit ? 0 : (1 << e.lane));
                chk("exit_ack", 32'(exit_ack), e.is_exit ? (1 << e.lane) : 0);
                chk("exit_err", 32'(exit_err), 32'(e.err));
                chk("grant_occ", 32'(occupancy), e.occ);
            end else begin
                chk("idle_acks", 32'({exit_ack, entry_ack}), 0);
                chk("idle_err", 32'(exit_err), 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        ereq = '0; xreq = '0;
        @(negedge clk);
        step(1);

        // single entry on lane 0, gate held for G cycles
        ereq = 4'b0001; run(14);

        // four entries, round-robin order 0..3
        step(1);
        ereq = 4'b1111; run(14);

        // fill the lot, then a blocked entry released by an exit
        step(1);
        for (int n = 0; n < 300 && occ < NS; n++) begin ereq = '1; step(0); end
        run(1);
        ereq = 4'b0010; run(12);
        xreq = 4'b0100; run(20);

        // same-cycle exit and entry on different lanes at occupancy 3
        step(1);
        ereq = 4'b0111; run(22);
        ereq = 4'b0100; xreq = 4'b0001; run(14);

        // exit from an empty lot, then reset while the barrier is open
        step(1);
        xreq = 4'b0001; run(3);
        step(1); run(4);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 3) == 0) ereq[i] = 1'b1;
                if ($urandom_range(0, 5) == 0) xreq[i] = 1'b1;
            end
            step($urandom_range(0, 399) == 0);
        end

        ereq = '0; xreq = '0; run(4);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
Shares the parking-lot slot bookkeeping between several entry and exit lanes.
- Serialises lane requests through a round-robin arbiter; exits have priority over entries.
- Maintains the occupancy count.
- Drives a per-lane barrier with its own open timer.
- Sits between lane sensors/ticket readers and the slot-allocation datapath; it issues exactly one slot transaction at a time.

Parameters:
NUM_LANES, 4, number of lanes; each lane has one entry request and one exit request.
NUM_SLOTS, 8, lot capacity.
GATE_OPEN_CYCLES, 8, cycles a barrier stays open after a grant (>=1).

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
entry_req  input  NUM_LANES  per-lane entry request, level, held until entry_ack
exit_req  input  NUM_LANES  per-lane exit request, level, held until exit_ack
entry_ack  output  NUM_LANES  one-cycle grant pulse, one-hot
exit_ack  output  NUM_LANES  one-cycle grant pulse, one-hot
gate_open  output  NUM_LANES  barrier open per lane
occupancy  output  $clog2(NUM_SLOTS+1)  cars currently parked
full  output  1  occupancy == NUM_SLOTS, combinational from occupancy
exit_err  output  1  one-cycle pulse: exit granted while occupancy == 0
busy  output  1  FSM in GRANT state

Behaviour:
- Reset values:
  - acks 0, gate_open 0, occupancy 0, exit_err 0, busy 0.
  - Both RR pointers 0; all lane timers 0; state IDLE.
- Reset mid-operation: all barriers close in the same cycle; any pending grant is dropped.
- Lane eligibility: a lane whose gate_open=1 is masked from both arbiters.
- FSM, two states:
  - IDLE:
    - Any eligible exit_req: pick the exit winner round-robin from exit_ptr, register winner/type, go to GRANT.
    - Else, any eligible entry_req and !full: pick the entry winner round-robin from entry_ptr, go to GRANT.
    - Else stay in IDLE.
  - GRANT (exactly 1 cycle):
    - Assert the matching ack bit.
    - Set gate_open[w]=1 and load timer[w]=GATE_OPEN_CYCLES.
    - Update occupancy: entry +1; exit -1, saturating at 0 with exit_err pulsed if it was 0.
    - Set the relevant pointer to (w+1) mod NUM_LANES.
    - Return to IDLE.
- Latency: a request present in an IDLE cycle T is acked at T+1, with gate_open rising at T+1. The next grant is no earlier than T+3 (IDLE at T+2, GRANT at T+3).
- Timers:
  - Each nonzero timer decrements every cycle.
  - gate_open[i] = (timer[i] != 0).
  - The gate is therefore high for exactly GATE_OPEN_CYCLES cycles starting at the ack cycle.
- Round-robin search starts at the pointer index, ascending, wrapping from NUM_LANES-1 to 0.
- Full: entry requests stay pending, with no ack and no loss, while exits proceed. A pending entry is served on the first IDLE cycle after occupancy drops.
- Simultaneous entry_req and exit_req on one lane: exit served first; the entry is then masked until that lane's gate closes.
- Requester protocol: drop req in the cycle after ack.
  - The scheduler does not re-grant a lane while its gate is open.
  - A req held through gate close is treated as a new request.
- occupancy never exceeds NUM_SLOTS; no entry is granted when full.

Optional Feature:
Macro PARK_STATS_EN.
- Defined:
  - Adds outputs total_entries[15:0] and total_exits[15:0].
  - Each increments on the corresponding GRANT, wraps 16'hFFFF -> 0, and clears on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then entry_req=4'b0001 held -> entry_ack=4'b0001 one cycle later; occupancy 1; gate_open[0] high for exactly 8 cycles.
- entry_req=4'b1111 held from IDLE, each lane dropping its req after its ack -> acks in order lanes 0,1,2,3, one every 2 cycles; occupancy 4.
- Fill to 8, then entry_req[1]=1 -> no ack, full=1. Then exit_req[2]=1 -> exit_ack[2], occupancy 7, followed by entry_ack[1], occupancy 8.
- entry_req=4'b0100 and exit_req=4'b0001 in the same cycle, occupancy 3 -> exit_ack[0] first (occupancy 2), entry_ack[2] next (occupancy 3).
- Exit with occupancy 0 -> exit_ack pulses, exit_err pulses, occupancy stays 0. Then rst asserted while gate_open[0]=1 -> gate_open=0 next edge, occupancy 0.
- With PARK_STATS_EN: 3 entries and 1 exit -> total_entries=3, total_exits=1.
